// File: rtl/dsk_sector_server.sv
// Serves 512-byte sector reads/writes for two drives from a disk image in SDRAM.
// Latency: sd_ack 2 cycles after request; read 3 cycles/byte, write 4 cycles/byte with 1-cycle mem_ack.
// Backpressure: holds mem_rd/mem_wr until mem_ack; the served request bit must drop before a new request is taken.
module dsk_sector_server #(
    parameter logic [22:0] BASE0 = 23'h200000,
    parameter logic [22:0] BASE1 = 23'h300000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [31:0] sd_lba,
    input  logic [1:0]  sd_rd,
    input  logic [1:0]  sd_wr,
    output logic        sd_ack,
    output logic [8:0]  sd_buff_addr,
    output logic [7:0]  sd_buff_dout,
    input  logic [7:0]  sd_buff_din,
    output logic        sd_buff_wr,
    input  logic [31:0] img_size0,
    input  logic [31:0] img_size1,
    output logic [22:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    input  logic        mem_ack,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, ACCEPT, RD_REQ, RD_PUT, WR_ADDR, WR_SAMPLE, WR_REQ, DONE
    } state_t;

    state_t      state;
    logic        drv;        // drive being served
    logic        dir_wr;     // 1 = write to memory, 0 = read from memory
    logic        in_range;   // whole sector lies inside the image
    logic [31:0] lba;
    logic [8:0]  cnt;        // byte index within the sector

    logic [8:0]  cnt_nxt;
    logic        last_byte;
    logic [22:0] base;
    logic [31:0] img_size;
    logic [41:0] end_byte;
    logic        acc_in_range;
    logic [22:0] addr_first;
    logic [22:0] addr_nxt;
    logic        req_bit;

    assign cnt_nxt    = cnt + 9'd1;
    assign last_byte  = (cnt == 9'd511);
    assign base       = drv ? BASE1 : BASE0;
    assign img_size   = drv ? img_size1 : img_size0;
    // End of the sector in bytes; 42 bits so that lba = 2^32-1 cannot wrap into range.
    assign end_byte   = {({1'b0, lba} + 33'd1), 9'd0};
    assign acc_in_range = (end_byte <= {10'd0, img_size});
    // Address arithmetic wraps modulo 2^23, matching the SDRAM byte port.
    assign addr_first = base + {lba[13:0], 9'd0};
    assign addr_nxt   = base + {lba[13:0], cnt_nxt};
    assign req_bit    = dir_wr ? sd_wr[drv] : sd_rd[drv];

    // Sector transfer sequencer; every output is registered here.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= IDLE;
            drv          <= 1'b0;
            dir_wr       <= 1'b0;
            in_range     <= 1'b0;
            lba          <= 32'd0;
            cnt          <= 9'd0;
            sd_ack       <= 1'b0;
            sd_buff_addr <= 9'd0;
            sd_buff_dout <= 8'd0;
            sd_buff_wr   <= 1'b0;
            mem_addr     <= 23'd0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_din      <= 8'd0;
            err          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if ((|sd_rd) || (|sd_wr)) begin
                        lba   <= sd_lba;
                        state <= ACCEPT;
                        // Reads first (drive 0 ahead of drive 1), then writes in the same drive order.
                        if (sd_rd[0]) begin
                            drv <= 1'b0; dir_wr <= 1'b0;
                        end else if (sd_rd[1]) begin
                            drv <= 1'b1; dir_wr <= 1'b0;
                        end else if (sd_wr[0]) begin
                            drv <= 1'b0; dir_wr <= 1'b1;
                        end else begin
                            drv <= 1'b1; dir_wr <= 1'b1;
                        end
                    end
                end
                ACCEPT: begin
                    sd_ack       <= 1'b1;
                    cnt          <= 9'd0;
                    in_range     <= acc_in_range;
                    sd_buff_addr <= 9'd0;
                    mem_addr     <= addr_first;
                    if (!acc_in_range) begin
                        err <= 1'b1;
                    end
                    if (dir_wr) begin
                        state <= WR_ADDR;
                    end else begin
                        mem_rd <= acc_in_range;
                        state  <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (!in_range) begin
                        sd_buff_dout <= 8'hFF;
                        sd_buff_addr <= cnt;
                        sd_buff_wr   <= 1'b1;
                        state        <= RD_PUT;
                    end else if (mem_ack) begin
                        mem_rd       <= 1'b0;
                        sd_buff_dout <= mem_dout;
                        sd_buff_addr <= cnt;
                        sd_buff_wr   <= 1'b1;
                        state        <= RD_PUT;
                    end
                end
                RD_PUT: begin
                    sd_buff_wr <= 1'b0;
                    if (last_byte) begin
                        sd_ack <= 1'b0;
                        state  <= DONE;
                    end else begin
                        cnt      <= cnt_nxt;
                        mem_addr <= addr_nxt;
                        mem_rd   <= in_range;
                        state    <= RD_REQ;
                    end
                end
                WR_ADDR: begin
                    // sd_buff_addr already shows cnt; the requester answers next cycle.
                    state <= WR_SAMPLE;
                end
                WR_SAMPLE: begin
                    mem_din <= sd_buff_din;
                    mem_wr  <= in_range;
                    state   <= WR_REQ;
                end
                WR_REQ: begin
                    if (!in_range || mem_ack) begin
                        mem_wr <= 1'b0;
                        if (last_byte) begin
                            sd_ack <= 1'b0;
                            state  <= DONE;
                        end else begin
                            cnt          <= cnt_nxt;
                            sd_buff_addr <= cnt_nxt;
                            mem_addr     <= addr_nxt;
                            state        <= WR_ADDR;
                        end
                    end
                end
                DONE: begin
                    if (!req_bit) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsk_sector_server.sv
// Directed bench for dsk_sector_server: SDRAM byte-port responder, sector-buffer requester, scoreboard checks.
// Latency: measures request-to-ack, per-byte rate and ack-fall timing via a cycle counter.
// Backpressure: memory ack latency fixed or random 1-7 cycles.
module tb_dsk_sector_server;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd, sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic [7:0]  sd_buff_din;
    logic        sd_buff_wr;
    logic [31:0] img_size0, img_size1;
    logic [22:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        mem_ack;
    logic        err;

    always #5 clk_sys = ~clk_sys;

    dsk_sector_server dut (
        .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .img_size0(img_size0),
        .img_size1(img_size1), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack), .err(err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- memory model and responder ----------------
    logic [7:0] wmem [int];
    bit         rand_lat = 1'b0;
    int         fix_lat  = 1;
    bit         pending  = 1'b0;
    bit         pwr;
    int         pcnt;
    int         drop_cnt = 0;
    int acc_a_q[$], acc_d_q[$], acc_w_q[$], acc_c_q[$];

    // Untouched memory reads back its own low address byte.
    function automatic logic [7:0] mread(input logic [22:0] a);
        if (wmem.exists(int'(a))) return wmem[int'(a)];
        return a[7:0];
    endfunction

    initial begin
        mem_ack  = 1'b0;
        mem_dout = 8'hEE;
        forever begin
            @(posedge clk_sys); #1;
            if (mem_ack) begin
                mem_ack  = 1'b0;
                mem_dout = 8'hEE;
            end else if (pending) begin
                if (!(pwr ? mem_wr : mem_rd)) drop_cnt++;
                pcnt--;
                if (pcnt == 0) begin
                    pending = 1'b0;
                    mem_ack = 1'b1;
                    if (pwr) wmem[int'(mem_addr)] = mem_din;
                    else     mem_dout = mread(mem_addr);
                    acc_a_q.push_back(int'(mem_addr));
                    acc_d_q.push_back(pwr ? int'(mem_din) : int'(mem_dout));
                    acc_w_q.push_back(pwr ? 1 : 0);
                    acc_c_q.push_back(cyc);
                end
            end else if (mem_rd || mem_wr) begin
                pending = 1'b1;
                pwr     = mem_wr;
                pcnt    = rand_lat ? int'($urandom_range(7, 1)) : fix_lat;
            end
        end
    end

    // Requester returns buffer data one cycle after it sees the address.
    logic [8:0] last_addr = 9'd0;
    initial begin
        sd_buff_din = 8'd0;
        forever begin
            @(posedge clk_sys); #1;
            sd_buff_din = last_addr[7:0] ^ 8'h5A;
            last_addr   = sd_buff_addr;
        end
    end

    // ---------------- monitor ----------------
    int buf_a_q[$], buf_d_q[$], buf_c_q[$];
    int rd_cyc_n, wr_cyc_n, both_n, rise_c, fall_c;
    bit prev_ack = 1'b0;

    always @(negedge clk_sys) begin
        if (sd_buff_wr) begin
            buf_a_q.push_back(int'(sd_buff_addr));
            buf_d_q.push_back(int'(sd_buff_dout));
            buf_c_q.push_back(cyc);
        end
        if (mem_rd) rd_cyc_n++;
        if (mem_wr) wr_cyc_n++;
        if (mem_rd && mem_wr) both_n++;
        if (sd_ack && !prev_ack) rise_c = cyc;
        if (!sd_ack && prev_ack) fall_c = cyc;
        prev_ack = sd_ack;
    end

    task automatic clear_logs();
        buf_a_q.delete(); buf_d_q.delete(); buf_c_q.delete();
        acc_a_q.delete(); acc_d_q.delete(); acc_w_q.delete(); acc_c_q.delete();
        rd_cyc_n = 0; wr_cyc_n = 0;
        rise_c = 0; fall_c = 0;
    endtask

    task automatic wait_ack(input bit level, input string tag);
        int n = 0;
        while (sd_ack !== level && n < 20000) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk(tag, sd_ack, level);
    endtask

    // Called at posedge+1 with the DUT idle; requester drops its bit once acked.
    task automatic run_xfer(input bit drv, input bit wr, input logic [31:0] lba);
        clear_logs();
        sd_lba = lba;
        if (wr) sd_wr[drv] = 1'b1; else sd_rd[drv] = 1'b1;
        @(posedge clk_sys); #1;
        chk("ack_early", sd_ack, 1'b0);
        @(posedge clk_sys); #1;
        chk("ack_rise", sd_ack, 1'b1);
        if (wr) sd_wr[drv] = 1'b0; else sd_rd[drv] = 1'b0;
        wait_ack(1'b0, "ack_fall_timeout");
        repeat (3) @(posedge clk_sys);
        #1;
    endtask

    // mode 0: data = index, mode 1: index ^ 5A, mode 2: all FF.
    task automatic chk_strobes(input string tag, input int mode);
        logic [7:0] e;
        chk({tag, "_count"}, buf_a_q.size(), 512);
        for (int k = 0; k < buf_a_q.size(); k++) begin
            e = (mode == 2) ? 8'hFF : (8'(k) ^ ((mode == 1) ? 8'h5A : 8'h00));
            chk({tag, "_addr"}, buf_a_q[k], k);
            chk({tag, "_data"}, buf_d_q[k], e);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_sd_ack"}, sd_ack, 0);
        chk({tag, "_buff_wr"}, sd_buff_wr, 0);
        chk({tag, "_mem_rd"}, mem_rd, 0);
        chk({tag, "_mem_wr"}, mem_wr, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_buff_addr"}, sd_buff_addr, 0);
        chk({tag, "_buff_dout"}, sd_buff_dout, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_din"}, mem_din, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; sd_rd = 2'b00; sd_wr = 2'b00; sd_lba = 32'd0;
        img_size0 = 32'd8192; img_size1 = 32'd8192;
        repeat (3) @(posedge clk_sys);
        #1;
        chk_reset_outs("rst");
        reset = 1'b0;
        @(posedge clk_sys); #1;

        // Read in range: drive 0, lba 3 -> 0x200600..0x2007FF.
        run_xfer(1'b0, 1'b0, 32'd3);
        chk_strobes("rd", 0);
        chk("rd_nacc", acc_a_q.size(), 512);
        for (int k = 0; k < acc_a_q.size(); k++) chk("rd_mem_addr", acc_a_q[k], 32'h200600 + k);
        chk("rd_err", err, 0);
        chk("rd_duration", fall_c - rise_c, 1536);
        chk("rd_rd_cycles", rd_cyc_n, 1024);
        if (buf_c_q.size() == 512) chk("rd_ack_after_last", fall_c - buf_c_q[511], 1);

        // Write in range: drive 1, lba 0 -> 0x300000..0x3001FF, data index ^ 5A.
        run_xfer(1'b1, 1'b1, 32'd0);
        chk("wr_no_strobe", buf_a_q.size(), 0);
        chk("wr_nacc", acc_a_q.size(), 512);
        for (int k = 0; k < acc_a_q.size(); k++) begin
            chk("wr_mem_addr", acc_a_q[k], 32'h300000 + k);
            chk("wr_mem_data", acc_d_q[k], (k & 255) ^ 32'h5A);
            chk("wr_is_write", acc_w_q[k], 1);
        end
        chk("wr_duration", fall_c - rise_c, 2048);
        chk("wr_rd_cycles", rd_cyc_n, 0);
        if (acc_c_q.size() == 512) chk("wr_ack_after_last", fall_c - acc_c_q[511], 1);

        // Simultaneous: sd_rd=11, sd_wr=01 -> d0 read, d1 read, d0 write.
        clear_logs();
        sd_lba = 32'd1; sd_rd = 2'b11; sd_wr = 2'b01;
        for (int t = 0; t < 3; t++) begin
            wait_ack(1'b1, "sim_ack_timeout");
            if (t == 0) sd_rd[0] = 1'b0;
            else if (t == 1) sd_rd[1] = 1'b0;
            else sd_wr[0] = 1'b0;
            wait_ack(1'b0, "sim_done_timeout");
            chk("sim_nacc", acc_a_q.size(), 512);
            if (acc_a_q.size() > 0) begin
                chk("sim_first_addr", acc_a_q[0], (t == 1) ? 32'h300200 : 32'h200200);
                chk("sim_dir", acc_w_q[0], (t == 2) ? 1 : 0);
            end
            acc_a_q.delete(); acc_d_q.delete(); acc_w_q.delete(); acc_c_q.delete();
        end
        sd_rd = 2'b00; sd_wr = 2'b00;
        repeat (3) @(posedge clk_sys);
        #1;

        // Random latency 1-7: same data as the fixed-latency read, request never dropped early.
        rand_lat = 1'b1; drop_cnt = 0;
        run_xfer(1'b0, 1'b0, 32'd3);
        rand_lat = 1'b0;
        chk_strobes("rlat", 0);
        for (int k = 0; k < acc_a_q.size(); k++) chk("rlat_mem_addr", acc_a_q[k], 32'h200600 + k);
        chk("rlat_req_held", drop_cnt, 0);
        chk("rlat_never_both", both_n, 0);

        // Boundary: lba 1 with 1024-byte image is exactly in range; reads back the earlier write.
        img_size0 = 32'd1024;
        run_xfer(1'b0, 1'b0, 32'd1);
        chk_strobes("bnd", 1);
        chk("bnd_err", err, 0);

        // Out of range read: lba 2 -> FF bytes, no memory access, err set.
        run_xfer(1'b0, 1'b0, 32'd2);
        chk_strobes("oor_rd", 2);
        chk("oor_rd_no_mem", rd_cyc_n, 0);
        chk("oor_rd_err", err, 1);
        chk("oor_rd_duration", fall_c - rise_c, 1024);

        // Out of range write: discarded, 3 cycles/byte.
        run_xfer(1'b0, 1'b1, 32'd2);
        chk("oor_wr_no_mem", wr_cyc_n, 0);
        chk("oor_wr_no_strobe", buf_a_q.size(), 0);
        chk("oor_wr_err", err, 1);
        chk("oor_wr_duration", fall_c - rise_c, 1536);

        // Reset while byte 100 of a read is outstanding; late ack must be ignored.
        img_size0 = 32'd8192; fix_lat = 5;
        clear_logs();
        sd_lba = 32'd3; sd_rd = 2'b01;
        n = 0;
        while (!(buf_a_q.size() == 100 && mem_rd) && n < 5000) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk("rst100_reached", buf_a_q.size(), 100);
        reset = 1'b1; sd_rd = 2'b00;
        @(posedge clk_sys); #1;
        chk_reset_outs("rst100");
        @(posedge clk_sys); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk_sys);
        #1;
        chk("late_ack_no_strobe", buf_a_q.size(), 100);
        chk("late_ack_idle", sd_ack, 0);
        fix_lat = 1;

        // Fresh request after reset starts at byte 0.
        run_xfer(1'b0, 1'b0, 32'd3);
        chk_strobes("fresh", 0);
        chk("fresh_err", err, 0);

        // Largest lba must not wrap into range.
        img_size0 = 32'hFFFF_FFFF;
        run_xfer(1'b0, 1'b0, 32'hFFFF_FFFF);
        chk("big_no_mem", rd_cyc_n, 0);
        chk("big_err", err, 1);
        chk("big_count", buf_a_q.size(), 512);
        if (buf_d_q.size() > 0) chk("big_data", buf_d_q[0], 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
